// File: rtl/dac_spi_master_pkg.sv
// Shared definitions for the DAC SPI master: FSM encodings, frame geometry
// and channel addresses, reused by the peripheral model and benches.
package dac_spi_master_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SETUP    = 3'd1;
    localparam state_t ST_SHIFT_HI = 3'd2;
    localparam state_t ST_SHIFT_LO = 3'd3;
    localparam state_t ST_GAP      = 3'd4;

    localparam int         FRAME_BITS = 24;
    localparam logic [3:0] ADDR_A     = 4'h0;
    localparam logic [3:0] ADDR_B     = 4'h1;

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0]  cmd,
                                                         input logic [3:0]  addr,
                                                         input logic [15:0] data);
        return {cmd, addr, data};
    endfunction

endpackage

// File: rtl/dac_sck_div.sv
// Programmable tick generator: one-cycle tick every 'period' clocks,
// restarted whenever the FSM enters a new state.
module dac_sck_div (
    input  logic       Clk,
    input  logic       Reset_,
    input  logic       clear,
    input  logic [7:0] period,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = (cnt == period - 8'd1);

    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            cnt <= 8'd0;
        end else if (clear || tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dac_spi_master.sv
// Dual-channel DAC SPI master: each accepted sample pair becomes two 24-bit
// frames (channel A then B), MSB first, SCK idle low, SDI updated on SCK fall.
module dac_spi_master #(
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CMD     = 4'h3,
    parameter int         CS_GAP  = 2
) (
    input  logic        Clk,
    input  logic        Reset_,
    input  logic        SampleValid,
    output logic        SampleReady,
    input  logic [15:0] ChanA,
    input  logic [15:0] ChanB,
    output logic        SCK,
    output logic        SDI,
    output logic        CS_,
    output logic        Busy
);

    import dac_spi_master_pkg::*;

    state_t                  state;
    state_t                  state_nxt;
    logic                    tick;
    logic                    enter;
    logic [7:0]              period;
    logic                    hs;
    logic [4:0]              bit_cnt;
    logic                    chan_b;
    logic [FRAME_BITS-1:0]   shreg;
    logic [15:0]             b_q;
    logic                    ready_q;
    logic                    sck_q;
    logic                    cs_q;

    assign hs          = SampleValid && ready_q;
    assign enter       = (state_nxt != state);
    assign period      = (state == ST_GAP) ? 8'(CS_GAP) : 8'(CLK_DIV);
    assign SampleReady = ready_q;
    assign SCK         = sck_q;
    assign CS_         = cs_q;
    assign SDI         = shreg[FRAME_BITS-1];
    assign Busy        = (state != ST_IDLE);

    dac_sck_div u_div (
        .Clk    (Clk),
        .Reset_ (Reset_),
        .clear  (enter),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (hs)   state_nxt = ST_SETUP;
            ST_SETUP:    if (tick) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: if (tick) state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick) state_nxt = (bit_cnt == 5'd0) ? ST_GAP : ST_SHIFT_HI;
            ST_GAP:      if (tick) state_nxt = chan_b ? ST_IDLE : ST_SETUP;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // SPI outputs are registered from the next state so they change exactly on state entry
    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            chan_b  <= 1'b0;
            bit_cnt <= 5'd0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
            sck_q   <= (state_nxt == ST_SHIFT_HI);
            cs_q    <= (state_nxt == ST_IDLE) || (state_nxt == ST_GAP);

            if (hs) begin
                chan_b <= 1'b0;
            end else if (state == ST_GAP && tick) begin
                chan_b <= 1'b1;
            end

            // Channel A is taken straight from the port on the handshake edge
            if (enter && state_nxt == ST_SETUP) begin
                bit_cnt <= 5'(FRAME_BITS - 1);
                shreg   <= hs ? make_frame(CMD, ADDR_A, ChanA) : make_frame(CMD, ADDR_B, b_q);
            end else if (enter && state_nxt == ST_SHIFT_LO) begin
                shreg <= shreg << 1;
            end

            if (state == ST_SHIFT_LO && tick && bit_cnt != 5'd0) begin
                bit_cnt <= bit_cnt - 5'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (hs) begin
            b_q <= ChanB;
        end
    end

endmodule

// File: tb/tb_dac_spi_master.sv
// Self-checking bench for dac_spi_master with an SPI DAC peripheral model
// and a frame scoreboard.
module tb_dac_spi_master;

    logic        Clk = 1'b0;
    logic        Reset_ = 1'b0;
    logic        SampleValid = 1'b0;
    logic        SampleReady;
    logic [15:0] ChanA = 16'h0;
    logic [15:0] ChanB = 16'h0;
    logic        SCK;
    logic        SDI;
    logic        CS_;
    logic        Busy;

    dac_spi_master dut (
        .Clk         (Clk),
        .Reset_      (Reset_),
        .SampleValid (SampleValid),
        .SampleReady (SampleReady),
        .ChanA       (ChanA),
        .ChanB       (ChanB),
        .SCK         (SCK),
        .SDI         (SDI),
        .CS_         (CS_),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [23:0] exp_q[$];

    // Peripheral model: shifts on SCK rise, latches a frame when CS_ rises after 24 bits
    logic [23:0] m_sh      = 24'h0;
    int          m_bits    = 0;
    int          frames_rx = 0;
    logic [15:0] ChanAData = 16'h0;
    logic [15:0] ChanBData = 16'h0;
    logic [7:0]  CtrlA     = 8'h0;
    logic [7:0]  CtrlB     = 8'h0;

    always @(posedge SCK or posedge CS_) begin
        if (CS_ === 1'b1) begin
            if (m_bits == 24) begin
                frames_rx++;
                if (m_sh[19:16] == 4'h0) begin
                    ChanAData = m_sh[15:0];
                    CtrlA     = m_sh[23:16];
                end else if (m_sh[19:16] == 4'h1) begin
                    ChanBData = m_sh[15:0];
                    CtrlB     = m_sh[23:16];
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame: got %h, expected no frame", m_sh);
                end else begin
                    check("frame", {8'h0, m_sh}, {8'h0, exp_q.pop_front()});
                end
            end
            m_bits = 0;
        end else begin
            m_sh   = {m_sh[22:0], SDI};
            m_bits = m_bits + 1;
        end
    end

    int cyc = 0;
    int sck_total = 0;
    always @(posedge Clk) cyc++;
    always @(posedge SCK) sck_total++;

    int   win_len_q[$];
    int   win_rise_q[$];
    int   gap_q[$];
    int   win_len = 0, win_rise = 0, gap_len = 0;
    int   sdi_viol = 0;
    int   ready_cycles = 0;
    logic cs_prev = 1'b1, sck_prev = 1'b0, sdi_prev = 1'b0;

    always @(negedge Clk) begin
        if (Reset_) begin
            if (CS_ === 1'b0) begin
                if (cs_prev) begin
                    if (gap_len > 0) gap_q.push_back(gap_len);
                    gap_len  = 0;
                    win_len  = 0;
                    win_rise = 0;
                end
                win_len++;
                if (SCK && !sck_prev) win_rise++;
            end else begin
                if (!cs_prev) begin
                    win_len_q.push_back(win_len);
                    win_rise_q.push_back(win_rise);
                end
                if (Busy) gap_len++;
                else gap_len = 0;
            end
            if (SCK && sck_prev && SDI !== sdi_prev) sdi_viol++;
            if (SampleReady) ready_cycles++;
        end
        cs_prev  = CS_;
        sck_prev = SCK;
        sdi_prev = SDI;
    end

    int hs_cyc = 0;

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                             input logic [23:0] fa, input logic [23:0] fb,
                             input bit hold, input bit push);
        bit got = 1'b0;
        @(posedge Clk);
        #1;
        ChanA = a;
        ChanB = b;
        SampleValid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge Clk);
            if (SampleReady) begin
                hs_cyc = cyc + 1;
                @(posedge Clk);
                got = 1'b1;
            end
        end
        check("handshake", {31'h0, got}, 32'h1);
        if (got && push) begin
            exp_q.push_back(fa);
            exp_q.push_back(fb);
        end
        #1;
        if (!hold) SampleValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge Clk);
            if (SampleReady && exp_q.size() == 0) done = 1'b1;
        end
        check("pair_complete", {31'h0, done}, 32'h1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [23:0] fa;
        logic [23:0] fb;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, g0, rc0, f0, target;
        bit hit;

        vecs[0] = '{16'h0000, 16'hFFFF, 24'h300000, 24'h31FFFF};
        vecs[1] = '{16'h8000, 16'h0001, 24'h308000, 24'h310001};
        vecs[2] = '{16'h5555, 16'hAAAA, 24'h305555, 24'h31AAAA};
        vecs[3] = '{16'h7FFF, 16'h8001, 24'h307FFF, 24'h318001};

        repeat (3) @(posedge Clk);
        #1;
        check("rst_sck",   {31'h0, SCK},         32'h0);
        check("rst_sdi",   {31'h0, SDI},         32'h0);
        check("rst_cs",    {31'h0, CS_},         32'h1);
        check("rst_ready", {31'h0, SampleReady}, 32'h0);
        check("rst_busy",  {31'h0, Busy},        32'h0);
        Reset_ = 1'b1;
        @(negedge Clk);
        check("ready_before_edge", {31'h0, SampleReady}, 32'h0);
        @(posedge Clk);
        #1;
        check("ready_first_edge", {31'h0, SampleReady}, 32'h1);

        // Single pair: timing and decoded contents
        w0 = win_len_q.size();
        g0 = gap_q.size();
        send_pair(16'h1234, 16'hABCD, 24'h301234, 24'h31ABCD, 1'b0, 1'b1);
        wait_idle();
        check("latency", cyc - hs_cyc, 397);
        check("windows", win_len_q.size() - w0, 2);
        if (win_len_q.size() - w0 >= 2) begin
            check("win_a_len",  win_len_q[w0],    196);
            check("win_b_len",  win_len_q[w0+1],  196);
            check("win_a_sck",  win_rise_q[w0],   24);
            check("win_b_sck",  win_rise_q[w0+1], 24);
        end
        check("gaps", gap_q.size() - g0, 1);
        if (gap_q.size() - g0 >= 1) check("gap_len", gap_q[g0], 2);
        check("model_a",  {16'h0, ChanAData}, 32'h1234);
        check("model_b",  {16'h0, ChanBData}, 32'hABCD);
        check("ctrl_a",   {24'h0, CtrlA},     32'h30);
        check("ctrl_b",   {24'h0, CtrlB},     32'h31);

        // Back-to-back pairs with SampleValid held high
        f0  = frames_rx;
        rc0 = 0;
        for (int i = 0; i < 4; i++) begin
            send_pair(vecs[i].a, vecs[i].b, vecs[i].fa, vecs[i].fb, i < 3, 1'b1);
            if (i == 0) rc0 = ready_cycles;
        end
        check("ready_one_cycle_per_pair", ready_cycles - rc0, 3);
        wait_idle();
        check("b2b_frames", frames_rx - f0, 8);

        // Input change one cycle after handshake must not leak into the frame
        send_pair(16'h1111, 16'h2222, 24'h301111, 24'h312222, 1'b0, 1'b1);
        @(posedge Clk);
        #1;
        ChanA = 16'hDEAD;
        ChanB = 16'hBEEF;
        wait_idle();
        check("hold_a", {16'h0, ChanAData}, 32'h1111);
        check("hold_b", {16'h0, ChanBData}, 32'h2222);

        // Reset asserted at the 10th SCK rise of frame A
        f0 = frames_rx;
        send_pair(16'h3333, 16'h4444, 24'h0, 24'h0, 1'b0, 1'b0);
        target = sck_total + 10;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(posedge Clk);
            #1;
            if (sck_total >= target) hit = 1'b1;
        end
        check("reach_10th_sck", {31'h0, hit}, 32'h1);
        Reset_ = 1'b0;
        #1;
        check("abort_cs",    {31'h0, CS_},         32'h1);
        check("abort_sck",   {31'h0, SCK},         32'h0);
        check("abort_sdi",   {31'h0, SDI},         32'h0);
        check("abort_busy",  {31'h0, Busy},        32'h0);
        check("abort_ready", {31'h0, SampleReady}, 32'h0);
        #1;
        check("abort_model_a", {16'h0, ChanAData}, 32'h1111);
        check("abort_frames",  frames_rx - f0, 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset_ = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        check("no_resume_busy", {31'h0, Busy}, 32'h0);
        check("no_resume_cs",   {31'h0, CS_},  32'h1);
        send_pair(16'h0F0F, 16'hF0F0, 24'h300F0F, 24'h31F0F0, 1'b0, 1'b1);
        wait_idle();
        check("post_reset_a", {16'h0, ChanAData}, 32'h0F0F);
        check("post_reset_b", {16'h0, ChanBData}, 32'hF0F0);

        check("sdi_stable_while_sck_high", sdi_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
